// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: forwarding, load-use/multi-cycle stalls, redirect flushes, stall watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int XLEN        = 32,
    parameter int WDOG_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_id_i,
    input  logic [4:0]      rs2_id_i,
    input  logic            rs1_used_id_i,
    input  logic            rs2_used_id_i,
    input  logic [4:0]      wr_ex_i,
    input  logic            rf_we_ex_i,
    input  logic [1:0]      wd_sel_ex_i,
    input  logic [XLEN-1:0] wd_ex_i,
    input  logic [4:0]      wr_mem_i,
    input  logic            rf_we_mem_i,
    input  logic [XLEN-1:0] wd_mem_i,
    input  logic [4:0]      wr_wb_i,
    input  logic            rf_we_wb_i,
    input  logic [XLEN-1:0] wd_wb_i,
    input  logic            md_busy_ex_i,
    input  logic            redirect_ex_i,
    output logic            stall_pc_o,
    output logic            stall_if_id_o,
    output logic            flush_if_id_o,
    output logic            flush_id_ex_o,
    output logic            fwd_rD1e_o,
    output logic            fwd_rD2e_o,
    output logic [XLEN-1:0] fwd_rD1_o,
    output logic [XLEN-1:0] fwd_rD2_o,
    output logic            hazard_err_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cyc_o,
    output logic [31:0]     perf_flush_cnt_o
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MD_WAIT  = 2'd2;
    localparam logic [8:0] WDOG_LIM    = 9'(WDOG_CYCLES);

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic            ex_fwd_ok_s;
    logic            load_use_s;
    logic            fwd1_sel_s;
    logic            fwd2_sel_s;
    logic [XLEN-1:0] fwd1_val_s;
    logic [XLEN-1:0] fwd2_val_s;
    logic            stall_s;
    logic            flush_if_s;
    logic            flush_ex_s;
    logic [7:0]      wdog_cnt_r;
    logic [8:0]      wdog_inc_s;
    logic            hazard_err_r;

    function automatic logic src_match(input logic used, input logic [4:0] rs,
                                       input logic we, input logic [4:0] wr);
        return used && (rs != 5'd0) && we && (wr == rs);
    endfunction

    // A loaded value is not yet available in EX, so EX forwarding skips loads and lets MEM/WB answer.
    function automatic logic [XLEN:0] fwd_pick(input logic on, input logic used, input logic [4:0] rs,
                                               input logic ex_ok, input logic [4:0] wr_ex,
                                               input logic [XLEN-1:0] wd_ex,
                                               input logic we_mem, input logic [4:0] wr_mem,
                                               input logic [XLEN-1:0] wd_mem,
                                               input logic we_wb, input logic [4:0] wr_wb,
                                               input logic [XLEN-1:0] wd_wb);
        logic [XLEN:0] res;
        if (!on) begin
            res = {1'b0, {XLEN{1'b0}}};
        end else if (src_match(used, rs, ex_ok, wr_ex)) begin
            res = {1'b1, wd_ex};
        end else if (src_match(used, rs, we_mem, wr_mem)) begin
            res = {1'b1, wd_mem};
        end else if (src_match(used, rs, we_wb, wr_wb)) begin
            res = {1'b1, wd_wb};
        end else begin
            res = {1'b0, {XLEN{1'b0}}};
        end
        return res;
    endfunction

    assign ex_fwd_ok_s = rf_we_ex_i && (wd_sel_ex_i != 2'b01);

    assign load_use_s = rf_we_ex_i && (wd_sel_ex_i == 2'b01) && (wr_ex_i != 5'd0) &&
                        ((rs1_used_id_i && (rs1_id_i == wr_ex_i)) ||
                         (rs2_used_id_i && (rs2_id_i == wr_ex_i)));

    assign {fwd1_sel_s, fwd1_val_s} = fwd_pick(rst_n, rs1_used_id_i, rs1_id_i, ex_fwd_ok_s, wr_ex_i, wd_ex_i,
                                               rf_we_mem_i, wr_mem_i, wd_mem_i, rf_we_wb_i, wr_wb_i, wd_wb_i);
    assign {fwd2_sel_s, fwd2_val_s} = fwd_pick(rst_n, rs2_used_id_i, rs2_id_i, ex_fwd_ok_s, wr_ex_i, wd_ex_i,
                                               rf_we_mem_i, wr_mem_i, wd_mem_i, rf_we_wb_i, wr_wb_i, wd_wb_i);

    // Stall/flush decode and next state; every state re-evaluates the current inputs with the same priority.
    always_comb begin
        stall_s     = 1'b0;
        flush_if_s  = 1'b0;
        flush_ex_s  = 1'b0;
        state_nxt_s = ST_RUN;
        if (!rst_n) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN, ST_LU_STALL, ST_MD_WAIT: begin
                    if (redirect_ex_i) begin
                        flush_if_s  = 1'b1;
                        flush_ex_s  = 1'b1;
                        state_nxt_s = ST_RUN;
                    end else if (md_busy_ex_i) begin
                        stall_s     = 1'b1;
                        state_nxt_s = ST_MD_WAIT;
                    end else if (load_use_s) begin
                        stall_s     = 1'b1;
                        flush_ex_s  = 1'b1;
                        state_nxt_s = ST_LU_STALL;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign wdog_inc_s = {1'b0, wdog_cnt_r} + 9'd1;

    // Consecutive-stall watchdog with a sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_r   <= 8'd0;
            hazard_err_r <= 1'b0;
        end else if (stall_s) begin
            if (wdog_cnt_r != 8'hFF) begin
                wdog_cnt_r <= wdog_inc_s[7:0];
            end
            if (wdog_inc_s >= WDOG_LIM) begin
                hazard_err_r <= 1'b1;
            end
        end else begin
            wdog_cnt_r <= 8'd0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;

    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_r <= 32'd0;
            perf_flush_r <= 32'd0;
        end else begin
            if (stall_s) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
            if (flush_if_s) begin
                perf_flush_r <= perf_flush_r + 32'd1;
            end
        end
    end

    assign perf_stall_cyc_o = perf_stall_r;
    assign perf_flush_cnt_o = perf_flush_r;
`endif

    assign stall_pc_o    = stall_s;
    assign stall_if_id_o = stall_s;
    assign flush_if_id_o = flush_if_s;
    assign flush_id_ex_o = flush_ex_s;
    assign fwd_rD1e_o    = fwd1_sel_s;
    assign fwd_rD2e_o    = fwd2_sel_s;
    assign fwd_rD1_o     = fwd1_val_s;
    assign fwd_rD2_o     = fwd2_val_s;
    assign hazard_err_o  = hazard_err_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;
    localparam int WDOG = 64;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_id_i, rs2_id_i, wr_ex_i, wr_mem_i, wr_wb_i;
    logic        rs1_used_id_i, rs2_used_id_i, rf_we_ex_i, rf_we_mem_i, rf_we_wb_i;
    logic [1:0]  wd_sel_ex_i;
    logic [31:0] wd_ex_i, wd_mem_i, wd_wb_i;
    logic        md_busy_ex_i, redirect_ex_i;
    logic        stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o;
    logic        fwd_rD1e_o, fwd_rD2e_o, hazard_err_o;
    logic [31:0] fwd_rD1_o, fwd_rD2_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cyc_o, perf_flush_cnt_o;
`endif

    logic [69:0] dut_vec, exp_vec;
    logic        exp_err;
    int          run_len, stall_total, flush_total;
    int          vectors, miscompares;

    hazard_ctrl #(.XLEN(32), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id_i(rs1_id_i), .rs2_id_i(rs2_id_i),
        .rs1_used_id_i(rs1_used_id_i), .rs2_used_id_i(rs2_used_id_i),
        .wr_ex_i(wr_ex_i), .rf_we_ex_i(rf_we_ex_i), .wd_sel_ex_i(wd_sel_ex_i), .wd_ex_i(wd_ex_i),
        .wr_mem_i(wr_mem_i), .rf_we_mem_i(rf_we_mem_i), .wd_mem_i(wd_mem_i),
        .wr_wb_i(wr_wb_i), .rf_we_wb_i(rf_we_wb_i), .wd_wb_i(wd_wb_i),
        .md_busy_ex_i(md_busy_ex_i), .redirect_ex_i(redirect_ex_i),
        .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
        .fwd_rD1e_o(fwd_rD1e_o), .fwd_rD2e_o(fwd_rD2e_o),
        .fwd_rD1_o(fwd_rD1_o), .fwd_rD2_o(fwd_rD2_o),
        .hazard_err_o(hazard_err_o)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cyc_o(perf_stall_cyc_o), .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
    );

    assign dut_vec = {stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o,
                      fwd_rD1e_o, fwd_rD2e_o, fwd_rD1_o, fwd_rD2_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        rs1_id_i = 5'd0; rs2_id_i = 5'd0; rs1_used_id_i = 1'b0; rs2_used_id_i = 1'b0;
        wr_ex_i = 5'd0; rf_we_ex_i = 1'b0; wd_sel_ex_i = 2'b00; wd_ex_i = 32'd0;
        wr_mem_i = 5'd0; rf_we_mem_i = 1'b0; wd_mem_i = 32'd0;
        wr_wb_i = 5'd0; rf_we_wb_i = 1'b0; wd_wb_i = 32'd0;
        md_busy_ex_i = 1'b0; redirect_ex_i = 1'b0;
    endtask

    // Reference: producers scanned in pipeline order, first eligible writer wins.
    task automatic model_eval();
        logic [4:0]  prd [3];
        logic        pok [3];
        logic [31:0] pval [3];
        logic        s1, s2, lu, st, fi, fe;
        logic [31:0] v1, v2;
        prd[0] = wr_ex_i;  pok[0] = rf_we_ex_i && (wd_sel_ex_i != 2'b01); pval[0] = wd_ex_i;
        prd[1] = wr_mem_i; pok[1] = rf_we_mem_i; pval[1] = wd_mem_i;
        prd[2] = wr_wb_i;  pok[2] = rf_we_wb_i;  pval[2] = wd_wb_i;
        s1 = 1'b0; v1 = 32'd0; s2 = 1'b0; v2 = 32'd0;
        for (int i = 0; i < 3; i++) begin
            if (!s1 && rs1_used_id_i && rs1_id_i != 5'd0 && pok[i] && prd[i] == rs1_id_i) begin
                s1 = 1'b1; v1 = pval[i];
            end
            if (!s2 && rs2_used_id_i && rs2_id_i != 5'd0 && pok[i] && prd[i] == rs2_id_i) begin
                s2 = 1'b1; v2 = pval[i];
            end
        end
        lu = rf_we_ex_i && wd_sel_ex_i == 2'b01 && wr_ex_i != 5'd0 &&
             ((rs1_used_id_i && rs1_id_i == wr_ex_i) || (rs2_used_id_i && rs2_id_i == wr_ex_i));
        st = !redirect_ex_i && (md_busy_ex_i || lu);
        fi = redirect_ex_i;
        fe = redirect_ex_i || (!md_busy_ex_i && lu);
        if (!rst_n) exp_vec = 70'd0;
        else        exp_vec = {st, st, fi, fe, s1, s2, v1, v2};
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst_n) begin
            if (exp_vec[69]) begin
                stall_total++;
                run_len++;
            end else begin
                run_len = 0;
            end
            if (run_len >= WDOG) exp_err = 1'b1;
            if (exp_vec[67]) flush_total++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        run_len = 0; stall_total = 0; flush_total = 0; exp_err = 1'b0;
        #3;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        rs1_id_i = 5'd3; rs1_used_id_i = 1'b1; wr_ex_i = 5'd3; rf_we_ex_i = 1'b1; wd_ex_i = 32'h55;
        md_busy_ex_i = 1'b1; redirect_ex_i = 1'b1;
        #1;
        vectors++;
        if (dut_vec !== 70'd0) begin
            $display("FAIL reset_comb: got %h required 0", dut_vec); miscompares++;
        end
        vectors++;
        if (hazard_err_o !== 1'b0) begin
            $display("FAIL reset_err: got %b required 0", hazard_err_o); miscompares++;
        end
        do_reset();
    endtask

    task automatic test_fwd_ex();
        clear_inputs();
        wr_ex_i = 5'd5; rf_we_ex_i = 1'b1; wd_sel_ex_i = 2'b00; wd_ex_i = 32'h11;
        rs1_id_i = 5'd5; rs1_used_id_i = 1'b1;
        #1;
        vectors++;
        if ({fwd_rD1e_o, fwd_rD1_o, stall_pc_o} !== {1'b1, 32'h11, 1'b0}) begin
            $display("FAIL fwd_ex: got %b/%h/%b required 1/11/0", fwd_rD1e_o, fwd_rD1_o, stall_pc_o); miscompares++;
        end
        rs1_id_i = 5'd0;
        #1;
        vectors++;
        if ({fwd_rD1e_o, fwd_rD1_o} !== {1'b0, 32'h0}) begin
            $display("FAIL fwd_x0: got %b/%h required 0/0", fwd_rD1e_o, fwd_rD1_o); miscompares++;
        end
        tick();
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        wr_ex_i = 5'd9; rf_we_ex_i = 1'b1; wd_ex_i = 32'hA;
        wr_mem_i = 5'd9; rf_we_mem_i = 1'b1; wd_mem_i = 32'hB;
        wr_wb_i = 5'd9; rf_we_wb_i = 1'b1; wd_wb_i = 32'hC;
        rs2_id_i = 5'd9; rs2_used_id_i = 1'b1;
        #1;
        vectors++;
        if ({fwd_rD2e_o, fwd_rD2_o, stall_pc_o} !== {1'b1, 32'hA, 1'b0}) begin
            $display("FAIL fwd_prio_ex: got %b/%h/%b required 1/a/0", fwd_rD2e_o, fwd_rD2_o, stall_pc_o); miscompares++;
        end
        wd_sel_ex_i = 2'b01;
        #1;
        vectors++;
        if ({stall_pc_o, stall_if_id_o, flush_id_ex_o} !== 3'b111) begin
            $display("FAIL prio_lu_stall: got %b%b%b required 111", stall_pc_o, stall_if_id_o, flush_id_ex_o); miscompares++;
        end
        tick();
        rf_we_ex_i = 1'b0; wd_sel_ex_i = 2'b00;
        #1;
        vectors++;
        if ({fwd_rD2e_o, fwd_rD2_o, stall_pc_o} !== {1'b1, 32'hB, 1'b0}) begin
            $display("FAIL fwd_prio_mem: got %b/%h/%b required 1/b/0", fwd_rD2e_o, fwd_rD2_o, stall_pc_o); miscompares++;
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        wr_ex_i = 5'd7; rf_we_ex_i = 1'b1; wd_sel_ex_i = 2'b01;
        rs1_id_i = 5'd7; rs1_used_id_i = 1'b1;
        #1;
        vectors++;
        if ({stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o} !== 4'b1101) begin
            $display("FAIL load_use: got %b%b%b%b required 1101", stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o); miscompares++;
        end
        tick();
        rf_we_ex_i = 1'b0; wd_sel_ex_i = 2'b00; wr_ex_i = 5'd0;
        wr_mem_i = 5'd7; rf_we_mem_i = 1'b1; wd_mem_i = 32'hDEAD;
        #1;
        vectors++;
        if ({fwd_rD1e_o, fwd_rD1_o, stall_pc_o, flush_id_ex_o} !== {1'b1, 32'hDEAD, 2'b00}) begin
            $display("FAIL lu_mem_fwd: got %b/%h/%b%b required 1/dead/00", fwd_rD1e_o, fwd_rD1_o, stall_pc_o, flush_id_ex_o); miscompares++;
        end
        tick();
    endtask

    task automatic test_md_wait();
        int stalls;
        clear_inputs();
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            md_busy_ex_i = 1'b1;
            #1;
            if (stall_pc_o === 1'b1) stalls++;
            vectors++;
            if ({stall_pc_o, stall_if_id_o, flush_id_ex_o} !== 3'b110) begin
                $display("FAIL md_wait[%0d]: got %b%b%b required 110", i, stall_pc_o, stall_if_id_o, flush_id_ex_o); miscompares++;
            end
            tick();
        end
        md_busy_ex_i = 1'b0;
        #1;
        if (stall_pc_o === 1'b1) stalls++;
        vectors++;
        if (stalls !== 4) begin
            $display("FAIL md_stall_count: got %0d required 4", stalls); miscompares++;
        end
        tick();
    endtask

    task automatic test_redirect();
        clear_inputs();
        wr_ex_i = 5'd4; rf_we_ex_i = 1'b1; wd_sel_ex_i = 2'b01;
        rs2_id_i = 5'd4; rs2_used_id_i = 1'b1; redirect_ex_i = 1'b1;
        #1;
        vectors++;
        if ({stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o} !== 4'b0011) begin
            $display("FAIL redirect_lu: got %b%b%b%b required 0011", stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o); miscompares++;
        end
        tick();
        clear_inputs();
        md_busy_ex_i = 1'b1;
        tick();
        tick();
        redirect_ex_i = 1'b1;
        #1;
        vectors++;
        if ({stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o} !== 4'b0011) begin
            $display("FAIL redirect_md: got %b%b%b%b required 0011", stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o); miscompares++;
        end
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (dut_vec !== 70'd0) begin
            $display("FAIL redirect_run: got %h required 0", dut_vec); miscompares++;
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        md_busy_ex_i = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({dut_vec, hazard_err_o} !== 71'd0) begin
            $display("FAIL reset_mid_stall: got %h/%b required 0", dut_vec, hazard_err_o); miscompares++;
        end
        do_reset();
        #1;
        vectors++;
        if (dut_vec !== 70'd0) begin
            $display("FAIL post_reset_run: got %h required 0", dut_vec); miscompares++;
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rs1_id_i = 5'($urandom_range(0, 7)); rs2_id_i = 5'($urandom_range(0, 7));
            rs1_used_id_i = 1'($urandom); rs2_used_id_i = 1'($urandom);
            wr_ex_i = 5'($urandom_range(0, 7)); rf_we_ex_i = 1'($urandom);
            wd_sel_ex_i = 2'($urandom); wd_ex_i = $urandom;
            wr_mem_i = 5'($urandom_range(0, 7)); rf_we_mem_i = 1'($urandom); wd_mem_i = $urandom;
            wr_wb_i = 5'($urandom_range(0, 7)); rf_we_wb_i = 1'($urandom); wd_wb_i = $urandom;
            md_busy_ex_i = ($urandom_range(0, 7) == 0);
            redirect_ex_i = ($urandom_range(0, 9) == 0);
            #1;
            model_eval();
            vectors++;
            if (dut_vec !== exp_vec) begin
                $display("FAIL rand_comb[%0d]: got %h required %h", n, dut_vec, exp_vec); miscompares++;
            end
            tick();
            vectors++;
            if (hazard_err_o !== exp_err) begin
                $display("FAIL rand_err[%0d]: got %b required %b", n, hazard_err_o, exp_err); miscompares++;
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        if ({perf_stall_cyc_o, perf_flush_cnt_o} !== {32'(stall_total), 32'(flush_total)}) begin
            $display("FAIL rand_perf: got %0d/%0d required %0d/%0d", perf_stall_cyc_o, perf_flush_cnt_o, stall_total, flush_total);
            miscompares++;
        end
`endif
    endtask

    task automatic test_watchdog();
        do_reset();
        md_busy_ex_i = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            vectors++;
            if (hazard_err_o !== (k >= WDOG)) begin
                $display("FAIL wdog[%0d]: got %b required %b", k, hazard_err_o, (k >= WDOG)); miscompares++;
            end
        end
        md_busy_ex_i = 1'b0;
        tick();
        tick();
        vectors++;
        if (hazard_err_o !== 1'b1) begin
            $display("FAIL wdog_sticky: got %b required 1", hazard_err_o); miscompares++;
        end
`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        if (perf_stall_cyc_o !== 32'd70) begin
            $display("FAIL perf_stall70: got %0d required 70", perf_stall_cyc_o); miscompares++;
        end
`endif
        do_reset();
        vectors++;
        if (hazard_err_o !== 1'b0) begin
            $display("FAIL wdog_clear: got %b required 0", hazard_err_o); miscompares++;
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        run_len = 0; stall_total = 0; flush_total = 0; exp_err = 1'b0;
        rst_n = 1'b1;
        clear_inputs();
        test_reset();
        test_fwd_ex();
        test_fwd_priority();
        test_load_use();
        test_md_wait();
        test_redirect();
        test_reset_mid_stall();
        test_random();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
